pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Sink end of the pixel stream: accepts processed RGB pixels (8 bits per channel, one pixel per valid cycle) from the pixel-processing stage and writes them in raster order into an output frame memory (BRAM port A style write port).
- Tracks column/row position, flags stray pixels outside a frame, and signals frame completion so the controller can dump or display the result image.

Parameters:
IMG_W, 256, image width in pixels (>=2)
IMG_H, 256, image height in pixels (>=2)
ADDR_W, 16, memory address width; IMG_W*IMG_H <= 2**ADDR_W

Ports:
clka  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  1-cycle pulse: arm writer for a new frame
Rin  input  8  red channel of incoming pixel
Gin  input  8  green channel
Bin  input  8  blue channel
OKin  input  1  pixel valid; one pixel accepted per clka edge while high
mem_we  output  1  frame-memory write enable
mem_addr  output  ADDR_W  frame-memory write address
mem_data  output  24  {Rin,Gin,Bin} packed, R in [23:16]
col  output  ADDR_W  column of the next expected pixel
row  output  ADDR_W  row of the next expected pixel
busy  output  1  high while in WRITE state
done  output  1  1-cycle pulse after last pixel of frame written
overrun  output  1  sticky: pixel arrived while not armed

Behaviour:
- Reset (reset==0 at rising clka): state=IDLE; mem_we=0, mem_addr=0, mem_data=0, col=0, row=0, busy=0, done=0, overrun=0. Reset overrides all other inputs, including mid-frame; an aborted frame never produces done.
- States: IDLE, WRITE, DONE.
- IDLE: start=1 -> WRITE; pixel counter, col, row cleared to 0; overrun cleared. OKin=1 in IDLE (without start) -> pixel dropped, overrun<=1. start and OKin in the same IDLE cycle -> pixel dropped, overrun stays clear (start clear wins), first pixel is the next OKin.
- WRITE: busy=1. Each edge with OKin=1: mem_we<=1, mem_addr<=pixel counter, mem_data<={Rin,Gin,Bin}; counter+1; col+1, or col<=0 and row+1 when col==IMG_W-1. OKin=0 -> mem_we<=0, counters hold. Gaps in OKin of any length allowed.
- Write latency: registered outputs; pixel sampled at edge N appears on mem_* during cycle N+1 (mem_we high exactly one cycle per accepted pixel).
- Last pixel (counter==IMG_W*IMG_H-1 with OKin=1): write issued as normal, next state DONE; col/row wrap to 0/0.
- DONE: done=1 for exactly this one cycle, busy=0, mem_we=0; unconditionally -> IDLE. OKin=1 in DONE -> dropped, overrun<=1. start in DONE ignored.
- start while in WRITE: ignored (no restart, counters unaffected).
- Channel values are passed unmodified; no saturation or arithmetic on data.
- overrun only cleared by reset or by an accepted start.

Test Plan:
- Reset: hold reset=0 two cycles with OKin=1, start=1 -> all outputs 0, state IDLE, no mem_we.
- Full frame, IMG_W=4, IMG_H=2: start, then 8 consecutive OKin pixels R=i,G=2i,B=3i -> mem_we 8 cycles, addr 0..7, mem_data[i]={i,2i,3i}, row goes 0->1 after pixel 3, done pulses once the cycle after last write, busy then 0.
- Gapped stream: same frame, OKin toggling 1/0 -> still exactly 8 writes, addresses contiguous 0..7, done once.
- Stray pixel: OKin=1 in IDLE with no start -> no write, overrun=1; subsequent start -> overrun=0.
- Reset mid-frame: after 5 pixels, reset=0 one cycle -> outputs cleared, no done; new start + 8 pixels writes from addr 0.
- Start during WRITE and start+OKin same IDLE cycle: mid-frame start after 3 pixels leaves next addr=3; start+OKin together -> that pixel not written, first write at addr 0 is next valid pixel.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// Raster-order frame-memory writer: packs RGB pixels into 24-bit words, tracks
// column/row, pulses done after the last pixel and flags pixels seen while unarmed.
module pixel_frame_writer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        Rin,
  input  logic [7:0]        Gin,
  input  logic [7:0]        Bin,
  input  logic              OKin,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_data,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   col_q;
  logic [ADDR_W-1:0]   row_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [23:0]         data_q;
  logic                busy_q;
  logic                done_q;
  logic                ovr_q;

  // Frame FSM with all outputs registered
  always_ff @(posedge clka) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 24'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            // a pixel arriving together with start is dropped without flagging
            state_q <= S_WRITE;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ovr_q   <= 1'b0;
          end else if (OKin) begin
            ovr_q <= 1'b1;
          end else begin
            ovr_q <= ovr_q;
          end
        end
        S_WRITE: begin
          if (OKin) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            data_q <= {Rin, Gin, Bin};
            if (cnt_q == PIX_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              col_q   <= '0;
              row_q   <= '0;
            end else if (col_q == COL_LAST) begin
              cnt_q <= cnt_q + ADDR_W'(1);
              col_q <= '0;
              row_q <= row_q + ADDR_W'(1);
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
              col_q <= col_q + ADDR_W'(1);
            end
          end else begin
            we_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (OKin) begin
            ovr_q <= 1'b1;
          end else begin
            ovr_q <= ovr_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign col      = col_q;
  assign row      = row_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed self-checking bench for pixel_frame_writer on a 4x2 frame.
module tb_pixel_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 16;

  logic          clka;
  logic          reset;
  logic          start;
  logic [7:0]    Rin;
  logic [7:0]    Gin;
  logic [7:0]    Bin;
  logic          OKin;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_data;
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic          busy;
  logic          done;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  int ndone = 0;

  pixel_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clka(clka), .reset(reset), .start(start),
    .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .col(col), .row(row), .busy(busy), .done(done), .overrun(overrun)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // count write strobes and done pulses independently of the directed checks
  always @(negedge clka) begin
    if (mem_we) nwr++;
    if (done) ndone++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic send_px(input int i, input logic [7:0] base, input bit gap);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int nxt;
    r = base + 8'(i);
    g = base + 8'(2 * i);
    b = base + 8'(3 * i);
    OKin = 1'b1; Rin = r; Gin = g; Bin = b;
    step();
    OKin = 1'b0;
    nxt = (i + 1) % N;
    chk_eq("we", 32'(mem_we), 32'd1);
    chk_eq("addr", 32'(mem_addr), 32'(i));
    chk_eq("data", 32'(mem_data), 32'({r, g, b}));
    chk_eq("col", 32'(col), 32'(nxt % W));
    chk_eq("row", 32'(row), 32'(nxt / W));
    chk_eq("busy", 32'(busy), (i == N - 1) ? 32'd0 : 32'd1);
    chk_eq("done", 32'(done), (i == N - 1) ? 32'd1 : 32'd0);
    if (gap && i != N - 1) begin
      step();
      chk_eq("gap_we", 32'(mem_we), 32'd0);
      chk_eq("gap_col", 32'(col), 32'(nxt % W));
      chk_eq("gap_row", 32'(row), 32'(nxt / W));
    end
  endtask

  task automatic tail();
    OKin = 1'b0;
    step();
    chk_eq("tail_done", 32'(done), 32'd0);
    chk_eq("tail_busy", 32'(busy), 32'd0);
    chk_eq("tail_we", 32'(mem_we), 32'd0);
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("arm_busy", 32'(busy), 32'd1);
    chk_eq("arm_ovr", 32'(overrun), 32'd0);
    chk_eq("arm_col", 32'(col), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    chk_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk_eq({tag, "_data"}, 32'(mem_data), 32'd0);
    chk_eq({tag, "_col"}, 32'(col), 32'd0);
    chk_eq({tag, "_row"}, 32'(row), 32'd0);
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_done"}, 32'(done), 32'd0);
    chk_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    reset = 1'b0; start = 1'b1; OKin = 1'b1;
    Rin = 8'hFF; Gin = 8'hFF; Bin = 8'hFF;

    // reset held with start and OKin asserted
    step();
    step();
    check_cleared("rst");
    reset = 1'b1; start = 1'b0; OKin = 1'b0;
    step();
    check_cleared("idle");

    // full back-to-back frame
    arm();
    w0 = nwr; d0 = ndone;
    for (int i = 0; i < N; i++) send_px(i, 8'h00, 1'b0);
    tail();
    chk_eq("full_writes", 32'(nwr - w0), 32'd8);
    chk_eq("full_dones", 32'(ndone - d0), 32'd1);

    // gapped frame, data wraps through 8 bits
    arm();
    w0 = nwr; d0 = ndone;
    for (int i = 0; i < N; i++) send_px(i, 8'hF0, 1'b1);
    tail();
    chk_eq("gap_writes", 32'(nwr - w0), 32'd8);
    chk_eq("gap_dones", 32'(ndone - d0), 32'd1);

    // stray pixel in IDLE
    OKin = 1'b1;
    step();
    OKin = 1'b0;
    chk_eq("stray_we", 32'(mem_we), 32'd0);
    chk_eq("stray_ovr", 32'(overrun), 32'd1);
    step();
    chk_eq("stray_sticky", 32'(overrun), 32'd1);
    arm();
    for (int i = 0; i < N; i++) send_px(i, 8'h33, 1'b0);
    // stray pixel during the DONE cycle
    OKin = 1'b1;
    step();
    OKin = 1'b0;
    chk_eq("dstray_we", 32'(mem_we), 32'd0);
    chk_eq("dstray_done", 32'(done), 32'd0);
    chk_eq("dstray_ovr", 32'(overrun), 32'd1);

    // reset mid-frame
    arm();
    d0 = ndone;
    for (int i = 0; i < 5; i++) send_px(i, 8'h10, 1'b0);
    reset = 1'b0; OKin = 1'b1;
    step();
    check_cleared("midrst");
    reset = 1'b1; OKin = 1'b0;
    step();
    step();
    chk_eq("midrst_nodone", 32'(ndone - d0), 32'd0);
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    arm();
    w0 = nwr; d0 = ndone;
    for (int i = 0; i < N; i++) send_px(i, 8'h5A, 1'b0);
    tail();
    chk_eq("rerun_writes", 32'(nwr - w0), 32'd8);
    chk_eq("rerun_dones", 32'(ndone - d0), 32'd1);

    // start during WRITE is ignored
    arm();
    for (int i = 0; i < 3; i++) send_px(i, 8'h01, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("wstart_col", 32'(col), 32'd3);
    chk_eq("wstart_busy", 32'(busy), 32'd1);
    chk_eq("wstart_we", 32'(mem_we), 32'd0);
    for (int i = 3; i < N; i++) send_px(i, 8'h01, 1'b0);
    tail();

    // start and OKin together in IDLE: pixel dropped, overrun stays clear
    OKin = 1'b1;
    step();
    OKin = 1'b0;
    chk_eq("pre_ovr", 32'(overrun), 32'd1);
    start = 1'b1; OKin = 1'b1; Rin = 8'hAA; Gin = 8'hBB; Bin = 8'hCC;
    step();
    start = 1'b0; OKin = 1'b0;
    chk_eq("so_we", 32'(mem_we), 32'd0);
    chk_eq("so_busy", 32'(busy), 32'd1);
    chk_eq("so_ovr", 32'(overrun), 32'd0);
    chk_eq("so_col", 32'(col), 32'd0);
    w0 = nwr; d0 = ndone;
    for (int i = 0; i < N; i++) send_px(i, 8'h77, 1'b0);
    tail();
    chk_eq("so_writes", 32'(nwr - w0), 32'd8);
    chk_eq("so_dones", 32'(ndone - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
